ammo_magazine: RTL and testbench

Ammunition bookkeeping and launch sequencer for the three air-defence batteries; it is the producer side of the per-battery ammunition counts that the display-digit stage consumes. On a fire request it selects the battery whose radar alone reports a target, runs a fixed-length launch pulse, and decrements that battery's count. Reload requests add to a battery's count with saturation. The three 5-bit counts are exported for digit conversion.

---
 rtl/ammo_pkg.sv | 44 ++++
 rtl/ammo_magazine_if.sv | 47 ++++
 rtl/ammo_counter.sv | 56 +++++
 rtl/ammo_magazine.sv | 148 ++++++++++++++
 tb/tb_ammo_magazine.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ammo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ammo_pkg
// Description : Shared types and helpers for the air-defence ammunition
//               magazine. Holds the sequencer state enum, the battery index
//               type and the radar-to-battery decode function.
// Revision    : 1.0 - initial release
// ============================================================================
package ammo_pkg;

    // Highest count whose tens digit still fits the 0..2 digit display range.
    localparam int MAX_AMMO_LIMIT = 29;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        LAUNCH = 2'd2
    } state_t;

    // Battery index: 0 = battery 1, 1 = battery 2, 2 = battery 3.
    typedef logic [1:0] bat_idx_t;

    typedef struct packed {
        logic     valid;
        bat_idx_t idx;
    } radar_sel_t;

    // A fire target is only unambiguous when exactly one radar reports.
    // radar bit 0 is battery 1.
    function automatic radar_sel_t radar_decode(input logic [2:0] radar);
        radar_sel_t r;
        r.valid = 1'b1;
        r.idx   = 2'd0;
        case (radar)
            3'b001:  r.idx = 2'd0;
            3'b010:  r.idx = 2'd1;
            3'b100:  r.idx = 2'd2;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ammo_magazine_if.sv
`default_nettype none
// ============================================================================
// Module      : ammo_magazine_if
// Description : Command / status bundle of the ammunition magazine.
//               master : fire and reload commander (drives radars, requests)
//               slave  : the magazine (drives counts, launch and status)
//   radar_1..3   target detected in battery 1..3 sector
//   fire_req     fire command
//   reload_req   single-cycle reload strobe, reload_sel 1..3 (0 = none)
//   reload_qty   rounds to add
//   ammunition_* per-battery counts      launch  one-hot launch drive
//   busy         ARM/LAUNCH in progress   fire_done / fire_err  pulses
//   empty        per-battery zero-count flags
// Revision    : 1.0 - initial release
// ============================================================================
interface ammo_magazine_if;
    logic       radar_1;
    logic       radar_2;
    logic       radar_3;
    logic       fire_req;
    logic       reload_req;
    logic [1:0] reload_sel;
    logic [4:0] reload_qty;
    logic [4:0] ammunition_1;
    logic [4:0] ammunition_2;
    logic [4:0] ammunition_3;
    logic [2:0] launch;
    logic       busy;
    logic       fire_done;
    logic       fire_err;
    logic [2:0] empty;

    modport master (
        output radar_1, radar_2, radar_3, fire_req,
        output reload_req, reload_sel, reload_qty,
        input  ammunition_1, ammunition_2, ammunition_3,
        input  launch, busy, fire_done, fire_err, empty
    );

    modport slave (
        input  radar_1, radar_2, radar_3, fire_req,
        input  reload_req, reload_sel, reload_qty,
        output ammunition_1, ammunition_2, ammunition_3,
        output launch, busy, fire_done, fire_err, empty
    );
endinterface
`default_nettype wire

// File: rtl/ammo_counter.sv
`default_nettype none
// ============================================================================
// Module      : ammo_counter
// Description : One battery's ammunition count with saturating reload and
//               single-round decrement. A decrement and a reload in the same
//               cycle are merged so neither update is lost.
//   clock, reset_n  clock and synchronous active-low reset
//   dec             remove one round (never asserted at count 0)
//   inc_en, inc_qty reload strobe and rounds to add
//   count, empty    registered count and count==0 flag
// Revision    : 1.0 - initial release
// ============================================================================
module ammo_counter #(
    parameter int MAX_AMMO  = 29,
    parameter int INIT_AMMO = 20
) (
    input  wire logic       clock,
    input  wire logic       reset_n,
    input  wire logic       dec,
    input  wire logic       inc_en,
    input  wire logic [4:0] inc_qty,
    output logic      [4:0] count,
    output logic            empty
);

    localparam logic [5:0] c_max  = 6'(MAX_AMMO);
    localparam logic [4:0] c_init = 5'(INIT_AMMO);

    logic [4:0] r_count;
    logic       r_empty;
    logic [5:0] w_base;
    logic [5:0] w_sum;
    logic [4:0] w_next;

    // 6-bit arithmetic: 29 + 31 must not wrap before the clamp.
    always_comb begin
        w_base = {1'b0, r_count} - {5'd0, dec};
        w_sum  = w_base + (inc_en ? {1'b0, inc_qty} : 6'd0);
        w_next = (w_sum > c_max) ? c_max[4:0] : w_sum[4:0];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count <= c_init;
            r_empty <= (c_init == 5'd0);
        end else begin
            r_count <= w_next;
            r_empty <= (w_next == 5'd0);
        end
    end

    assign count = r_count;
    assign empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/ammo_magazine.sv
`default_nettype none
// ============================================================================
// Module      : ammo_magazine
// Description : Ammunition bookkeeping and launch sequencer for three
//               batteries. A fire request selects the single battery whose
//               radar reports, arms for one cycle, drives a FIRE_CYCLES-long
//               launch pulse and decrements that battery's count.
//   clock, reset_n  clock and synchronous active-low reset
//   bus             ammo_magazine_if.slave command/status bundle
// Revision    : 1.0 - initial release
// ============================================================================
module ammo_magazine
    import ammo_pkg::*;
#(
    parameter int MAX_AMMO    = 29,
    parameter int INIT_AMMO   = 20,
    parameter int FIRE_CYCLES = 4
) (
    input wire logic        clock,
    input wire logic        reset_n,
    ammo_magazine_if.slave  bus
);

    // Never let a caller push the ceiling past the displayable range.
    localparam int c_max_eff = (MAX_AMMO > MAX_AMMO_LIMIT) ? MAX_AMMO_LIMIT : MAX_AMMO;
    localparam int c_pw      = (FIRE_CYCLES > 1) ? $clog2(FIRE_CYCLES) : 1;
    localparam logic [c_pw-1:0] c_last = c_pw'(FIRE_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_next;
    bat_idx_t        r_idx;
    bat_idx_t        w_idx_next;
    logic [c_pw-1:0] r_pulse;
    logic [c_pw-1:0] w_pulse_next;
    logic [2:0]      r_launch;
    logic [2:0]      w_launch_next;
    logic            r_busy;
    logic            r_fire_done;
    logic            w_fire_done_next;
    logic            r_fire_err;
    logic            w_fire_err_next;
    logic            w_dec_en;

    logic [2:0]      w_radar;
    radar_sel_t      w_sel;
    logic [2:0]      w_has_ammo;
    logic            w_avail;
    logic [2:0]      w_inc_en;
    logic [2:0]      w_dec;
    logic [2:0]      w_empty;
    logic [4:0]      w_count [3];

    assign w_radar = {bus.radar_3, bus.radar_2, bus.radar_1};
    assign w_sel   = radar_decode(w_radar);
    // Only meaningful when the radars are one-hot: picks the reporting battery.
    assign w_avail = |(w_radar & w_has_ammo);

    for (genvar gi = 0; gi < 3; gi++) begin : g_bat
        assign w_inc_en[gi]   = bus.reload_req && (bus.reload_sel == 2'(gi + 1));
        assign w_dec[gi]      = w_dec_en && (r_idx == 2'(gi));
        assign w_has_ammo[gi] = (w_count[gi] != 5'd0);

        ammo_counter #(
            .MAX_AMMO  (c_max_eff),
            .INIT_AMMO (INIT_AMMO)
        ) u_counter (
            .clock   (clock),
            .reset_n (reset_n),
            .dec     (w_dec[gi]),
            .inc_en  (w_inc_en[gi]),
            .inc_qty (bus.reload_qty),
            .count   (w_count[gi]),
            .empty   (w_empty[gi])
        );
    end

    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_pulse_next     = r_pulse;
        w_fire_done_next = 1'b0;
        w_fire_err_next  = 1'b0;
        w_dec_en         = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.fire_req) begin
                    if (w_sel.valid && w_avail) begin
                        w_state_next = ARM;
                        w_idx_next   = w_sel.idx;
                    end else begin
                        w_fire_err_next = 1'b1;
                    end
                end
            end
            ARM: begin
                w_state_next = LAUNCH;
                w_pulse_next = '0;
            end
            LAUNCH: begin
                // The round leaves the count on the first launch cycle.
                w_dec_en = (r_pulse == '0);
                if (r_pulse == c_last) begin
                    w_state_next     = IDLE;
                    w_fire_done_next = 1'b1;
                end else begin
                    w_pulse_next = r_pulse + 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Registered outputs are decoded from the next state so they line up
        // with the state they describe.
        w_launch_next = (w_state_next == LAUNCH) ? (3'b001 << w_idx_next) : 3'b000;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_pulse     <= '0;
            r_launch    <= 3'b000;
            r_busy      <= 1'b0;
            r_fire_done <= 1'b0;
            r_fire_err  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_pulse     <= w_pulse_next;
            r_launch    <= w_launch_next;
            r_busy      <= (w_state_next != IDLE);
            r_fire_done <= w_fire_done_next;
            r_fire_err  <= w_fire_err_next;
        end
    end

    assign bus.ammunition_1 = w_count[0];
    assign bus.ammunition_2 = w_count[1];
    assign bus.ammunition_3 = w_count[2];
    assign bus.empty        = w_empty;
    assign bus.launch       = r_launch;
    assign bus.busy         = r_busy;
    assign bus.fire_done    = r_fire_done;
    assign bus.fire_err     = r_fire_err;

endmodule
`default_nettype wire

// File: tb/tb_ammo_magazine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ammo_magazine
// Description : Self-checking bench for ammo_magazine. A timeline model
//               (counts array plus "edges since accept") predicts every
//               output each cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ammo_magazine;

    localparam int FC   = 4;
    localparam int MAXA = 29;
    localparam int INIT = 20;

    logic clock;
    logic reset_n;
    int   tests;
    int   fails;

    ammo_magazine_if bus ();

    ammo_magazine #(
        .MAX_AMMO    (MAXA),
        .INIT_AMMO   (INIT),
        .FIRE_CYCLES (FC)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_cnt [3];
    int         m_phase;      // edges since the accepting edge, -1 when idle
    int         m_bat;
    bit         m_valid;
    logic       e_done;
    logic       e_err;
    int         dec_bat;
    int         radar;
    int         nv;

    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) m_cnt[i] = INIT;
            m_phase = -1;
            m_bat   = 0;
            e_done  = 1'b0;
            e_err   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            dec_bat = -1;
            e_done  = 1'b0;
            e_err   = 1'b0;
            if (m_phase >= 0) begin
                m_phase++;
                if (m_phase == 2) dec_bat = m_bat;
                if (m_phase == FC + 1) begin
                    e_done  = 1'b1;
                    m_phase = -1;
                end
            end else if (bus.fire_req) begin
                radar = {29'd0, bus.radar_3, bus.radar_2, bus.radar_1};
                if ((radar == 1 || radar == 2 || radar == 4) &&
                    m_cnt[(radar == 1) ? 0 : (radar == 2) ? 1 : 2] > 0) begin
                    m_bat   = (radar == 1) ? 0 : (radar == 2) ? 1 : 2;
                    m_phase = 0;
                end else begin
                    e_err = 1'b1;
                end
            end
            for (int i = 0; i < 3; i++) begin
                nv = m_cnt[i] - ((dec_bat == i) ? 1 : 0);
                if (bus.reload_req && int'(bus.reload_sel) == i + 1) nv += int'(bus.reload_qty);
                if (nv > MAXA) nv = MAXA;
                m_cnt[i] = nv;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (m_valid) begin
            check("ammunition_1", {27'd0, bus.ammunition_1}, m_cnt[0]);
            check("ammunition_2", {27'd0, bus.ammunition_2}, m_cnt[1]);
            check("ammunition_3", {27'd0, bus.ammunition_3}, m_cnt[2]);
            check("empty", {29'd0, bus.empty},
                  {29'd0, m_cnt[2] == 0, m_cnt[1] == 0, m_cnt[0] == 0});
            check("busy", {31'd0, bus.busy}, {31'd0, m_phase >= 0});
            check("launch", {29'd0, bus.launch},
                  (m_phase >= 1 && m_phase <= FC) ? (32'd1 << m_bat) : 32'd0);
            check("fire_done", {31'd0, bus.fire_done}, {31'd0, e_done});
            check("fire_err", {31'd0, bus.fire_err}, {31'd0, e_err});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic set_radar(input logic [2:0] r);
        bus.radar_1 = r[0];
        bus.radar_2 = r[1];
        bus.radar_3 = r[2];
    endtask

    task automatic reload(input logic [1:0] sel, input logic [4:0] qty);
        bus.reload_req = 1'b1;
        bus.reload_sel = sel;
        bus.reload_qty = qty;
        tick();
        bus.reload_req = 1'b0;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        m_valid = 1'b0;
        reset_n = 1'b0;
        set_radar(3'b000);
        bus.fire_req   = 1'b0;
        bus.reload_req = 1'b0;
        bus.reload_sel = 2'd0;
        bus.reload_qty = 5'd0;
        repeat (3) tick();
        reset_n = 1'b1;

        // Reset state
        check("rst_ammo1", {27'd0, bus.ammunition_1}, 20);
        check("rst_ammo2", {27'd0, bus.ammunition_2}, 20);
        check("rst_ammo3", {27'd0, bus.ammunition_3}, 20);
        check("rst_launch", {29'd0, bus.launch}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);

        // Fire battery 2
        set_radar(3'b010);
        bus.fire_req = 1'b1;
        tick();
        bus.fire_req = 1'b0;
        set_radar(3'b000);
        check("arm_busy", {31'd0, bus.busy}, 1);
        check("arm_launch", {29'd0, bus.launch}, 0);
        tick();
        check("launch_b2", {29'd0, bus.launch}, 3'b010);
        repeat (3) tick();
        check("launch_b2_last", {29'd0, bus.launch}, 3'b010);
        tick();
        check("fire_done_b2", {31'd0, bus.fire_done}, 1);
        check("fire_done_busy", {31'd0, bus.busy}, 0);
        check("ammo2_after", {27'd0, bus.ammunition_2}, 19);

        // Ambiguous radars
        set_radar(3'b101);
        bus.fire_req = 1'b1;
        tick();
        bus.fire_req = 1'b0;
        set_radar(3'b000);
        check("amb_err", {31'd0, bus.fire_err}, 1);
        check("amb_busy", {31'd0, bus.busy}, 0);
        tick();

        // Drain battery 1
        for (int n = 0; n < 20; n++) begin
            set_radar(3'b001);
            bus.fire_req = 1'b1;
            tick();
            bus.fire_req = 1'b0;
            repeat (FC + 1) tick();
        end
        check("drain_ammo1", {27'd0, bus.ammunition_1}, 0);
        check("drain_empty0", {31'd0, bus.empty[0]}, 1);
        bus.fire_req = 1'b1;
        tick();
        bus.fire_req = 1'b0;
        set_radar(3'b000);
        check("empty_fire_err", {31'd0, bus.fire_err}, 1);
        tick();
        check("empty_ammo1", {27'd0, bus.ammunition_1}, 0);

        // Reloads
        reload(2'd3, 5'd15);
        check("reload_sat", {27'd0, bus.ammunition_3}, 29);
        reload(2'd2, 5'd0);
        check("reload_zero", {27'd0, bus.ammunition_2}, 19);
        reload(2'd0, 5'd10);
        check("reload_none", {27'd0, bus.ammunition_1}, 0);

        // Combined decrement + reload, fire_req during LAUNCH ignored
        reload(2'd1, 5'd5);
        check("reload_b1", {27'd0, bus.ammunition_1}, 5);
        set_radar(3'b001);
        bus.fire_req = 1'b1;
        tick();
        bus.fire_req = 1'b0;
        tick();
        set_radar(3'b010);
        bus.fire_req   = 1'b1;
        bus.reload_req = 1'b1;
        bus.reload_sel = 2'd1;
        bus.reload_qty = 5'd3;
        tick();
        bus.fire_req   = 1'b0;
        bus.reload_req = 1'b0;
        set_radar(3'b000);
        check("combined_ammo1", {27'd0, bus.ammunition_1}, 7);
        check("ignored_launch", {29'd0, bus.launch}, 3'b001);
        repeat (4) tick();

        // Reset during the third launch cycle
        set_radar(3'b100);
        bus.fire_req = 1'b1;
        tick();
        bus.fire_req = 1'b0;
        set_radar(3'b000);
        repeat (3) tick();
        check("pre_rst_launch", {29'd0, bus.launch}, 3'b100);
        reset_n = 1'b0;
        tick();
        check("abort_launch", {29'd0, bus.launch}, 0);
        check("abort_busy", {31'd0, bus.busy}, 0);
        check("abort_done", {31'd0, bus.fire_done}, 0);
        check("abort_ammo3", {27'd0, bus.ammunition_3}, 20);
        reset_n = 1'b1;
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 9) < 6)
                set_radar(3'(3'b001 << $urandom_range(0, 2)));
            else
                set_radar(3'($urandom_range(0, 7)));
            bus.fire_req   = ($urandom_range(0, 9) < 4);
            bus.reload_req = ($urandom_range(0, 9) < 2);
            bus.reload_sel = 2'($urandom_range(0, 3));
            bus.reload_qty = 5'($urandom_range(0, 31));
            tick();
        end

        reset_n = 1'b1;
        set_radar(3'b000);
        bus.fire_req   = 1'b0;
        bus.reload_req = 1'b0;
        repeat (FC + 3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
